pipe_stall_sequencer: RTL and testbench
=======================================

Name: pipe_stall_sequencer

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline. It collects hazard stall requests from decode (forwarding and load-use), branch redirects resolved in decode, and instruction/data memory busy signals. From these it drives per-stage pipeline-register enables, bubble/flush controls and PC enable. It also tracks a redirect that arrives during an outstanding fetch, halts the machine on HALT commit, and keeps stall statistics plus a data-memory watchdog.

Parameters:
CNT_W, 16, width of saturating stall_cnt and flush_cnt
WD_LIMIT, 255, consecutive DWAIT cycles before err sets (1..2^WD_W-1)
WD_W, 8, watchdog counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset
haz_stall  in  1  decode hazard stall (forwarding stall OR load-use)
br_taken  in  1  decode branch/jump redirect; valid only when haz_stall=0
imem_stall  in  1  instruction memory not done this cycle
dmem_stall  in  1  data memory not done this cycle
halt_in  in  1  HALT instruction in MW stage
pc_en  out  1  PC register load enable
pc_use_held  out  1  PC loads held redirect target instead of next-PC mux
tgt_cap  out  1  fetch captures redirect target into hold register
fd_en  out  1  FD register enable
fd_flush  out  1  FD loads NOP
dx_en  out  1  DX register enable
dx_bubble  out  1  DX loads NOP
xm_en  out  1  XM register enable
mw_en  out  1  MW register enable
mw_bubble  out  1  MW loads NOP
halted  out  1  machine halted
err  out  1  sticky watchdog error
state  out  2  debug: 0 RUN, 1 DWAIT, 2 IWAIT, 3 HALT
stall_cnt  out  CNT_W  cycles with pc_en=0, outside HALT
flush_cnt  out  CNT_W  branch flushes

Behaviour:
- Reset, sampled at posedge with rst=0: state=RUN, redir_pend=0, wd_cnt=0, err=0, counters=0.
- While rst=0, outputs are forced as follows: all *_en=0, fd_flush=dx_bubble=mw_bubble=1, pc_use_held=tgt_cap=0, halted=0.
- Defaults: all en=1; flush, bubble, pc_use_held and tgt_cap = 0.
- The output decode is combinational from current state, redir_pend and inputs. Priority is highest first:
  - HALT state: all en=0, halted=1. Stays in HALT until reset; all inputs are ignored.
  - halt_in=1: mw_en=1; pc_en, fd_en, dx_en and xm_en =0. Next state = HALT.
  - dmem_stall=1: pc_en, fd_en, dx_en and xm_en =0; mw_en=1 with mw_bubble=1. Next state = DWAIT.
  - haz_stall=1: pc_en=fd_en=0; dx_bubble=1; xm and mw advance. br_taken is ignored.
  - imem_stall=1: pc_en=0; fd_flush=1; downstream stages advance. Next state = IWAIT. If br_taken is also 1, then tgt_cap=1 and redir_pend<=1 (flush_cnt +1).
  - br_taken=1 with imem_stall=0: pc_en=1, fd_flush=1, flush_cnt +1.
  - Else (in IWAIT with imem_stall=0 and redir_pend=1): the fetched instruction is stale, so fd_flush=1, pc_en=1, pc_use_held=1. redir_pend<=0. Next state = RUN.
- DWAIT: wd_cnt increments each cycle dmem_stall=1. When wd_cnt reaches WD_LIMIT, err<=1 (sticky until reset) and wd_cnt holds. When dmem_stall=0, the cycle uses the RUN rules and wd_cnt<=0. Next state = RUN, unless a rule above moves it elsewhere.
- IWAIT exits to RUN when imem_stall=0.
- A second br_taken while redir_pend=1 re-captures the target (tgt_cap=1). The newer target wins.
- Entering DWAIT from IWAIT preserves redir_pend.
- stall_cnt increments each cycle pc_en=0 while not in HALT and rst=1. stall_cnt and flush_cnt saturate at all-ones with no wrap.
- No combinational path from any output back to any input.

Test Plan:
- Reset then idle inputs: after the rst=0 cycle, all en=1, state=0, counters=0. While rst=0, en=0 and bubbles=1.
- haz_stall=1 for 2 cycles together with br_taken=1: pc_en=fd_en=0 and dx_bubble=1 for 2 cycles; flush_cnt stays 0; stall_cnt=2.
- dmem_stall=1 for 3 cycles: state=1, only mw_en=1 with mw_bubble=1, stall_cnt=3, then RUN. With WD_LIMIT=4 and a 6-cycle stall, err=1 persists.
- br_taken=1 and imem_stall=1 for 2 cycles: tgt_cap pulses in cycle 1. Next cycle with imem_stall=0: pc_use_held=1, pc_en=1, fd_flush=1, state returns to 0, flush_cnt=1.
- halt_in=1 together with dmem_stall=1: halt wins (mw_en=1, others 0), then state=3 and halted=1. Later dmem_stall/br_taken activity has no effect.
- CNT_W=4 with 20 stall cycles: stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stall_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, bubbles, held-redirect
// replay, HALT latch, stall/flush statistics and a data-memory watchdog.
//
// state | meaning
// RUN   | normal flow, single-cycle hazards resolved in place
// DWAIT | data memory busy, upstream frozen, MW fed bubbles
// IWAIT | instruction fetch outstanding, FD flushed each cycle
// HALT  | HALT committed, everything frozen until reset
module pipe_stall_sequencer #(
  parameter int CNT_W    = 16,
  parameter int WD_LIMIT = 255,
  parameter int WD_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             haz_stall,
  input  logic             br_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_in,
  output logic             pc_en,
  output logic             pc_use_held,
  output logic             tgt_cap,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_en,
  output logic             mw_en,
  output logic             mw_bubble,
  output logic             halted,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    HALT  = 2'd3
  } seqState_t;

  localparam logic [WD_W-1:0] wdLimit = WD_W'(WD_LIMIT);

  seqState_t       curState;
  seqState_t       nextState;
  logic            redirPend;
  logic            redirPendNext;
  logic            flushInc;
  logic            wdRun;
  logic [WD_W-1:0] wdCnt;
  logic [CNT_W-1:0] stallCntQ;
  logic [CNT_W-1:0] flushCntQ;
  logic            errQ;

  assign state     = curState;
  assign err       = errQ;
  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;

  always_comb begin
    pc_en         = 1'b1;
    fd_en         = 1'b1;
    dx_en         = 1'b1;
    xm_en         = 1'b1;
    mw_en         = 1'b1;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    mw_bubble     = 1'b0;
    pc_use_held   = 1'b0;
    tgt_cap       = 1'b0;
    halted        = 1'b0;
    nextState     = RUN;
    redirPendNext = redirPend;
    flushInc      = 1'b0;
    wdRun         = 1'b0;

    if (!rst) begin
      pc_en         = 1'b0;
      fd_en         = 1'b0;
      dx_en         = 1'b0;
      xm_en         = 1'b0;
      mw_en         = 1'b0;
      fd_flush      = 1'b1;
      dx_bubble     = 1'b1;
      mw_bubble     = 1'b1;
      redirPendNext = 1'b0;
    end else if (curState == HALT) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_en     = 1'b0;
      mw_en     = 1'b0;
      halted    = 1'b1;
      nextState = HALT;
    end else if (halt_in) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_en     = 1'b0;
      nextState = HALT;
    end else if (dmem_stall) begin
      // redirPend is deliberately left alone so a pending redirect survives DWAIT
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_en     = 1'b0;
      mw_bubble = 1'b1;
      wdRun     = 1'b1;
      nextState = DWAIT;
    end else if (haz_stall) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_bubble = 1'b1;
      nextState = imem_stall ? IWAIT : RUN;
    end else if (imem_stall) begin
      pc_en     = 1'b0;
      fd_flush  = 1'b1;
      nextState = IWAIT;
      if (br_taken) begin
        tgt_cap       = 1'b1;
        redirPendNext = 1'b1;
        flushInc      = 1'b1;
      end
    end else if (br_taken) begin
      fd_flush      = 1'b1;
      flushInc      = 1'b1;
      redirPendNext = 1'b0;
    end else if (redirPend) begin
      // the word fetched during the wait belongs to the old path
      fd_flush      = 1'b1;
      pc_use_held   = 1'b1;
      redirPendNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      curState  <= RUN;
      redirPend <= 1'b0;
      wdCnt     <= '0;
      errQ      <= 1'b0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      curState  <= nextState;
      redirPend <= redirPendNext;

      if (wdRun) begin
        if (wdCnt != wdLimit) wdCnt <= wdCnt + 1'b1;
        if (wdCnt >= wdLimit - 1'b1) errQ <= 1'b1;
      end else if (curState != HALT) begin
        wdCnt <= '0;
      end

      if (!pc_en && (curState != HALT) && !(&stallCntQ))
        stallCntQ <= stallCntQ + 1'b1;
      if (flushInc && !(&flushCntQ))
        flushCntQ <= flushCntQ + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Directed bench for pipe_stall_sequencer built with a 4-bit counter width and a
// watchdog limit of 4 so saturation and the error path are reachable quickly.
module tb_pipe_stall_sequencer;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, haz_stall, br_taken, imem_stall, dmem_stall, halt_in;
  logic pc_en, pc_use_held, tgt_cap, fd_en, fd_flush, dx_en, dx_bubble;
  logic xm_en, mw_en, mw_bubble, halted, err;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int nCmp = 0;
  int nBad = 0;

  pipe_stall_sequencer #(.CNT_W(CNT_W), .WD_LIMIT(4), .WD_W(8)) dut (
    .clk(clk), .rst(rst), .haz_stall(haz_stall), .br_taken(br_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_in(halt_in),
    .pc_en(pc_en), .pc_use_held(pc_use_held), .tgt_cap(tgt_cap),
    .fd_en(fd_en), .fd_flush(fd_flush), .dx_en(dx_en), .dx_bubble(dx_bubble),
    .xm_en(xm_en), .mw_en(mw_en), .mw_bubble(mw_bubble), .halted(halted),
    .err(err), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    haz_stall = 0; br_taken = 0; imem_stall = 0; dmem_stall = 0; halt_in = 0;
  endtask

  task automatic doReset();
    rst = 0; idle();
    tick();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 0; idle();
    #1;
    nCmp++; if ({pc_en, fd_en, dx_en, xm_en, mw_en} !== 5'b00000) begin nBad++; $display("FAIL rst_en: got %b want 00000", {pc_en, fd_en, dx_en, xm_en, mw_en}); end
    nCmp++; if ({fd_flush, dx_bubble, mw_bubble} !== 3'b111) begin nBad++; $display("FAIL rst_bubbles: got %b want 111", {fd_flush, dx_bubble, mw_bubble}); end
    nCmp++; if ({pc_use_held, tgt_cap, halted} !== 3'b000) begin nBad++; $display("FAIL rst_misc: got %b want 000", {pc_use_held, tgt_cap, halted}); end
    tick();
    rst = 1;
    #1;
    nCmp++; if ({pc_en, fd_en, dx_en, xm_en, mw_en} !== 5'b11111) begin nBad++; $display("FAIL idle_en: got %b want 11111", {pc_en, fd_en, dx_en, xm_en, mw_en}); end
    nCmp++; if ({fd_flush, dx_bubble, mw_bubble} !== 3'b000) begin nBad++; $display("FAIL idle_bubbles: got %b want 000", {fd_flush, dx_bubble, mw_bubble}); end
    nCmp++; if (state !== 2'd0) begin nBad++; $display("FAIL idle_state: got %0d want 0", state); end
    nCmp++; if ({stall_cnt, flush_cnt, err} !== {CNT_W'(0), CNT_W'(0), 1'b0}) begin nBad++; $display("FAIL idle_cnt: got stall=%0d flush=%0d err=%b want 0 0 0", stall_cnt, flush_cnt, err); end
  endtask

  task automatic test_hazard();
    doReset();
    haz_stall = 1; br_taken = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      nCmp++; if ({pc_en, fd_en, dx_bubble, xm_en, mw_en, fd_flush} !== 6'b001110) begin nBad++; $display("FAIL haz_ctrl[%0d]: got %b want 001110", i, {pc_en, fd_en, dx_bubble, xm_en, mw_en, fd_flush}); end
      tick();
    end
    idle();
    #1;
    nCmp++; if (flush_cnt !== CNT_W'(0)) begin nBad++; $display("FAIL haz_flush_cnt: got %0d want 0", flush_cnt); end
    nCmp++; if (stall_cnt !== CNT_W'(2)) begin nBad++; $display("FAIL haz_stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_dmem();
    doReset();
    dmem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCmp++; if ({pc_en, fd_en, dx_en, xm_en, mw_en, mw_bubble} !== 6'b000011) begin nBad++; $display("FAIL dmem_ctrl[%0d]: got %b want 000011", i, {pc_en, fd_en, dx_en, xm_en, mw_en, mw_bubble}); end
      tick();
      nCmp++; if (state !== 2'd1) begin nBad++; $display("FAIL dmem_state[%0d]: got %0d want 1", i, state); end
    end
    dmem_stall = 0;
    #1;
    nCmp++; if ({pc_en, mw_bubble} !== 2'b10) begin nBad++; $display("FAIL dmem_release: got %b want 10", {pc_en, mw_bubble}); end
    nCmp++; if (stall_cnt !== CNT_W'(3)) begin nBad++; $display("FAIL dmem_stall_cnt: got %0d want 3", stall_cnt); end
    nCmp++; if (err !== 1'b0) begin nBad++; $display("FAIL dmem_err_short: got %b want 0", err); end
    tick();
    nCmp++; if (state !== 2'd0) begin nBad++; $display("FAIL dmem_back_run: got %0d want 0", state); end
    dmem_stall = 1;
    for (int i = 0; i < 6; i++) tick();
    dmem_stall = 0;
    #1;
    nCmp++; if (err !== 1'b1) begin nBad++; $display("FAIL wd_err_set: got %b want 1", err); end
    tick(); tick();
    nCmp++; if (err !== 1'b1) begin nBad++; $display("FAIL wd_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_redirect();
    doReset();
    br_taken = 1; imem_stall = 1;
    #1;
    nCmp++; if ({tgt_cap, pc_en, fd_flush, pc_use_held} !== 4'b1010) begin nBad++; $display("FAIL redir_cap: got %b want 1010", {tgt_cap, pc_en, fd_flush, pc_use_held}); end
    tick();
    br_taken = 0;
    #1;
    nCmp++; if ({tgt_cap, state} !== {1'b0, 2'd2}) begin nBad++; $display("FAIL redir_wait: got cap=%b state=%0d want 0 2", tgt_cap, state); end
    tick();
    imem_stall = 0;
    #1;
    nCmp++; if ({pc_use_held, pc_en, fd_flush} !== 3'b111) begin nBad++; $display("FAIL redir_replay: got %b want 111", {pc_use_held, pc_en, fd_flush}); end
    tick();
    nCmp++; if ({state, pc_use_held} !== {2'd0, 1'b0}) begin nBad++; $display("FAIL redir_done: got state=%0d held=%b want 0 0", state, pc_use_held); end
    nCmp++; if (flush_cnt !== CNT_W'(1)) begin nBad++; $display("FAIL redir_flush_cnt: got %0d want 1", flush_cnt); end
  endtask

  task automatic test_back_to_back();
    doReset();
    br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCmp++; if ({pc_en, fd_flush, tgt_cap} !== 3'b110) begin nBad++; $display("FAIL b2b_ctrl[%0d]: got %b want 110", i, {pc_en, fd_flush, tgt_cap}); end
      tick();
    end
    idle();
    #1;
    nCmp++; if ({flush_cnt, stall_cnt} !== {CNT_W'(3), CNT_W'(0)}) begin nBad++; $display("FAIL b2b_cnt: got flush=%0d stall=%0d want 3 0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_halt();
    doReset();
    halt_in = 1; dmem_stall = 1;
    #1;
    nCmp++; if ({pc_en, fd_en, dx_en, xm_en, mw_en, mw_bubble} !== 6'b000010) begin nBad++; $display("FAIL halt_prio: got %b want 000010", {pc_en, fd_en, dx_en, xm_en, mw_en, mw_bubble}); end
    tick();
    halt_in = 0; br_taken = 1;
    #1;
    nCmp++; if ({state, halted, mw_en} !== {2'd3, 1'b1, 1'b0}) begin nBad++; $display("FAIL halt_state: got state=%0d halted=%b mw_en=%b want 3 1 0", state, halted, mw_en); end
    for (int i = 0; i < 5; i++) tick();
    nCmp++; if ({stall_cnt, flush_cnt} !== {CNT_W'(1), CNT_W'(0)}) begin nBad++; $display("FAIL halt_frozen_cnt: got stall=%0d flush=%0d want 1 0", stall_cnt, flush_cnt); end
    nCmp++; if ({state, err, fd_flush} !== {2'd3, 1'b0, 1'b0}) begin nBad++; $display("FAIL halt_ignore: got state=%0d err=%b flush=%b want 3 0 0", state, err, fd_flush); end
    idle();
  endtask

  task automatic test_saturation();
    doReset();
    haz_stall = 1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1;
    nCmp++; if (stall_cnt !== CNT_W'(15)) begin nBad++; $display("FAIL sat_stall_cnt: got %0d want 15", stall_cnt); end
  endtask

  initial begin
    rst = 0; idle();
    @(negedge clk);
    test_reset();
    test_hazard();
    test_dmem();
    test_redirect();
    test_back_to_back();
    test_halt();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
